// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO register-file arbiter.
// Optional write protection for requester 1 is enabled by defining PIO_ARB_WRPROT_EN.
package pio_arb_pkg;

  localparam int         NUM_REQ    = 2;
  localparam int         DEF_ADDR_W = 14;
  localparam logic [1:0] BAR0_SEL   = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/pio_rr_arb2.sv
// Two-way round-robin pick; the last_grant register lives in the parent.
module pio_rr_arb2
  import pio_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
  input  logic               last_grant,
  output logic               grant,
  output logic               any_grant
);

  // On a tie the requester that did not win last time goes first
  always_comb begin
    any_grant = |elig;
    if (&elig) grant = ~last_grant;
    else       grant = elig[1];
  end

endmodule

// File: rtl/pio_reg_arbiter.sv
// Round-robin arbiter sharing the PIO register-file port between two requesters.
// Define PIO_ARB_WRPROT_EN to discard requester-1 writes outside BAR0 user space.
module pio_reg_arbiter
  import pio_arb_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [7:0]        req0_be,
  input  logic [31:0]       req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [31:0]       req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req1_be,
  input  logic [31:0]       req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [31:0]       req1_rdata,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_be,
  input  logic [31:0]       rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_be,
  output logic [31:0]       wr_data,
  output logic              wr_en,
  input  logic              wr_busy,
  output logic              prot_err
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  arb_state_t        state, state_nxt;
  logic              last_grant;
  logic [2:0]        cnt;
  logic              rid;
  logic [NUM_REQ-1:0] elig;
  logic              grant, any_grant, accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_be;
  logic [31:0]       sel_wdata;
  logic              discard;

  // A write stalled by wr_busy drops out of arbitration so it cannot block a read
  assign elig[0] = req0_valid & (~req0_we | ~wr_busy);
  assign elig[1] = req1_valid & (~req1_we | ~wr_busy);

  pio_rr_arb2 u_rr (
    .elig       (elig),
    .last_grant (last_grant),
    .grant      (grant),
    .any_grant  (any_grant)
  );

  assign accept    = (state == IDLE) & any_grant;
  assign sel_we    = grant ? req1_we    : req0_we;
  assign sel_addr  = grant ? req1_addr  : req0_addr;
  assign sel_be    = grant ? req1_be    : req0_be;
  assign sel_wdata = grant ? req1_wdata : req0_wdata;

`ifdef PIO_ARB_WRPROT_EN
  assign discard = grant & sel_we & (sel_addr[ADDR_W-1 -: 2] != BAR0_SEL);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n)              prot_err <= 1'b0;
    else if (accept && discard)  prot_err <= 1'b1;
  end
`else
  assign discard  = 1'b0;
  assign prot_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!sel_we)      state_nxt = RD_WAIT;
          else if (!discard) state_nxt = WR;
        end
      end
      WR:      state_nxt = IDLE;
      RD_WAIT: if (cnt == 3'd1) state_nxt = RD_DONE;
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept & ~grant;
    req1_ready = accept &  grant;
  end

  // rd_addr/rd_be are held after a read so the register file sees a stable address
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_grant  <= 1'b1;
      cnt         <= 3'd0;
      rid         <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_be       <= '0;
      wr_data     <= '0;
      rd_addr     <= '0;
      rd_be       <= '0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      wr_en       <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      if (accept) begin
        last_grant <= grant;
        if (sel_we) begin
          if (!discard) begin
            wr_en   <= 1'b1;
            wr_addr <= sel_addr;
            wr_be   <= sel_be;
            wr_data <= sel_wdata;
          end
        end else begin
          rd_addr <= sel_addr;
          rd_be   <= sel_be[3:0];
          cnt     <= LAT;
          rid     <= grant;
        end
      end
      if (state == RD_WAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          if (rid) begin
            req1_rvalid <= 1'b1;
            req1_rdata  <= rd_data;
          end else begin
            req0_rvalid <= 1'b1;
            req0_rdata  <= rd_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pio_reg_arbiter.sv
// Scoreboard bench for pio_reg_arbiter: stimulus pushes expected strobes/returns,
// a negedge monitor pops and compares them; honours PIO_ARB_WRPROT_EN.
module tb_pio_reg_arbiter;

  localparam int LAT = 3;
`ifdef PIO_ARB_WRPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [13:0] addr;
    logic [7:0]  be;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        req0_valid, req0_we, req0_ready, req0_rvalid;
  logic [13:0] req0_addr;
  logic [7:0]  req0_be;
  logic [31:0] req0_wdata, req0_rdata;
  logic        req1_valid, req1_we, req1_ready, req1_rvalid;
  logic [13:0] req1_addr;
  logic [7:0]  req1_be;
  logic [31:0] req1_wdata, req1_rdata;
  logic [13:0] rd_addr, wr_addr;
  logic [3:0]  rd_be;
  logic [31:0] rd_data, wr_data;
  logic [7:0]  wr_be;
  logic        wr_en, wr_busy, prot_err;

  int      total = 0;
  int      bad   = 0;
  int      cyc   = 0;
  wr_exp_t wq[$];
  rd_exp_t rq[$];
  wr_exp_t mon_w;

  pio_reg_arbiter #(.RD_LAT(LAT), .ADDR_W(14)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_be(req0_be),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_be(req1_be),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .rd_addr(rd_addr), .rd_be(rd_be), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en),
    .wr_busy(wr_busy), .prot_err(prot_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rf_model(input logic [13:0] a);
    if (a == 14'h1002) return 32'h0037_7600;
    return {18'h2A5, a};
  endfunction

  assign rd_data = rf_model(rd_addr);

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic sync(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for ready, then withdraw and record the expectation
  task automatic apply_stimulus(input int n, input logic we, input logic [13:0] addr,
                                input logic [7:0] be, input logic [31:0] wdata,
                                input bit fwd, output int t_acc);
    logic seen;
    if (n == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_be = be; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_be = be; req1_wdata = wdata;
    end
    t_acc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      seen = (n == 0) ? req0_ready : req1_ready;
      if (seen) begin
        t_acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    if (t_acc < 0) begin
      flag_fail($sformatf("ready_timeout_req%0d", n));
    end else if (we) begin
      if (fwd) wq.push_back('{t_acc + 1, addr, be, wdata});
    end else begin
      rq.push_back('{t_acc + LAT + 1, n, rf_model(addr)});
    end
  endtask

  task automatic mon_read(input int id, input logic [31:0] data);
    rd_exp_t e;
    if (rq.size() == 0) begin
      flag_fail($sformatf("unexpected_rvalid_req%0d", id));
    end else begin
      e = rq.pop_front();
      check_output("rd_requester", id, e.id);
      check_output("rd_cycle", cyc, e.cyc);
      check_output("rd_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (sys_rst_n === 1'b1) begin
      if (wr_en) begin
        if (wq.size() == 0) begin
          flag_fail("unexpected_wr_en");
        end else begin
          mon_w = wq.pop_front();
          check_output("wr_cycle", cyc, mon_w.cyc);
          check_output("wr_addr", wr_addr, mon_w.addr);
          check_output("wr_be", wr_be, mon_w.be);
          check_output("wr_data", wr_data, mon_w.data);
        end
      end
      if (req0_rvalid) mon_read(0, req0_rdata);
      if (req1_rvalid) mon_read(1, req1_rdata);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, t1, c;
    sys_rst_n = 1'b0;
    wr_busy   = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_be = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_be = '0; req1_wdata = '0;
    sync(2);

    check_output("rst_wr_en", wr_en, 0);
    check_output("rst_rd_addr", rd_addr, 0);
    check_output("rst_req0_rvalid", req0_rvalid, 0);
    check_output("rst_req1_rdata", req1_rdata, 0);
    check_output("rst_prot_err", prot_err, 0);
    sys_rst_n = 1'b1;
    sync(1);

    // Write tie: req0 first, req1 two cycles later
    fork
      apply_stimulus(0, 1'b1, 14'h1000, 8'hFF, 32'h0A00_15C8, 1'b1, t0);
      apply_stimulus(1, 1'b1, 14'h1004, 8'h0F, 32'h0A00_15FF, 1'b1, t1);
    join
    check_output("wr_tie_req1_after_req0", t1, t0 + 2);

    // Read tie after req1 won last: req0 first, req1 once the first read completes
    fork
      apply_stimulus(0, 1'b0, 14'h0040, 8'h0F, 32'h0, 1'b1, t0);
      begin
        apply_stimulus(1, 1'b0, 14'h1002, 8'h03, 32'h0, 1'b1, t1);
        for (int k = 1; k <= LAT; k++) begin
          @(negedge clk);
          check_output("rd_addr_stable", rd_addr, 14'h1002);
          check_output("rd_be_stable", rd_be, 4'h3);
        end
      end
    join
    check_output("rd_tie_req1_after_req0", t1, t0 + LAT + 2);
    sync(3);

    // Write stalled by wr_busy; the other requester's read proceeds
    c = cyc;
    wr_busy = 1'b1;
    fork
      apply_stimulus(0, 1'b1, 14'h1010, 8'hF0, 32'hDEAD_BEEF, 1'b1, t0);
      apply_stimulus(1, 1'b0, 14'h1020, 8'h0F, 32'h0, 1'b1, t1);
      begin
        repeat (5) @(posedge clk);
        #1 wr_busy = 1'b0;
      end
    join
    check_output("busy_read_first", t1, c);
    check_output("busy_write_after", t0, c + ((LAT + 2 > 5) ? LAT + 2 : 5));
    check_output("req0_rdata_held", req0_rdata, rf_model(14'h0040));
    sync(3);

    // Reset in the middle of a read aborts it without a return
    apply_stimulus(0, 1'b0, 14'h0123, 8'h0F, 32'h0, 1'b1, t0);
    sys_rst_n = 1'b0;
    rq.delete();
    #1;
    check_output("midrst_rd_addr", rd_addr, 0);
    check_output("midrst_req0_rdata", req0_rdata, 0);
    check_output("midrst_req1_rdata", req1_rdata, 0);
    check_output("midrst_wr_addr", wr_addr, 0);
    sync(3);
    sys_rst_n = 1'b1;
    sync(1);
    c = cyc;
    apply_stimulus(1, 1'b0, 14'h1002, 8'h0F, 32'h0, 1'b1, t1);
    check_output("post_rst_accept", t1, c);
    sync(LAT + 2);
    check_output("post_rst_rdata", req1_rdata, 32'h0037_7600);

    // Requester-1 write outside BAR0 user space, then the same write from requester 0
    apply_stimulus(1, 1'b1, 14'h3000, 8'hFF, 32'h1234_5678, !PROT, t0);
    check_output("prot_err_after_req1", prot_err, PROT);
    apply_stimulus(0, 1'b1, 14'h3000, 8'hFF, 32'h8765_4321, 1'b1, t1);
    check_output("req0_wr_accept_cycle", t1, PROT ? t0 + 1 : t0 + 2);
    sync(4);
    check_output("prot_err_sticky", prot_err, PROT);

    sync(10);
    check_output("wr_queue_drained", wq.size(), 0);
    check_output("rd_queue_drained", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_reg_arbiter.md
Name: pio_reg_arbiter

Overview:
Shares the single PIO register-file access port (14-bit word address, split read/write) between two requesters.
- Requester 0: PCIe PIO RX/TX engine.
- Requester 1: network-side remote configuration agent.
Uses round-robin arbitration and sequences each access: one-cycle write strobe, or a held read address with a fixed-latency data capture. Sits between the PIO engines and the register-file/BIOS-ROM access block.

Parameters:
RD_LAT, 1, cycles between rd_addr becoming valid and rd_data being sampled (1..7)
ADDR_W, 14, register-file word address width

Ports:
clk  in  1  system clock; all logic on rising edge
sys_rst_n  in  1  reset, asynchronous assert, active-low
req0_valid  in  1  requester 0 request; valid, we, addr, be and wdata held stable until req0_ready
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  word address
req0_be  in  8  byte enables; [3:0] used for reads
req0_wdata  in  32  write data
req0_ready  out  1  accept strobe; combinational
req0_rvalid  out  1  one-cycle read-return strobe
req0_rdata  out  32  read data, valid with req0_rvalid
req1_*  same set as req0_*, for requester 1
rd_addr  out  ADDR_W  register-file read address
rd_be  out  4  read byte enables
rd_data  in  32  register-file read data
wr_addr  out  ADDR_W  write address
wr_be  out  8  write byte enables
wr_data  out  32  write data
wr_en  out  1  one-cycle write strobe
wr_busy  in  1  write controller busy
prot_err  out  1  sticky write-protection violation (optional feature)

Behaviour:
- Reset (sys_rst_n low, asynchronous): state IDLE. All registered outputs are 0: wr_en, wr_addr, wr_be, wr_data, rd_addr, rd_be, reqN_rvalid, reqN_rdata, prot_err. RR pointer last_grant = 1, so req0 wins the first tie.
- Reset mid-operation aborts the access; no rvalid is issued and the requester reissues.
- FSM states: IDLE, WR, RD_WAIT, RD_DONE.
- IDLE, grant selection:
  - Only one valid: that requester is selected.
  - Both valid: the requester not equal to last_grant is selected.
- IDLE, acceptance: reqN_ready = (state==IDLE) & selected & (!reqN_we | !wr_busy).
  - A write with wr_busy high is not accepted and does not block a ready read from the other requester.
  - On acceptance, last_grant <= N.
- Write accepted in cycle t:
  - Cycle t+1: state WR, wr_en=1, wr_addr/wr_be/wr_data = captured fields.
  - Cycle t+2: IDLE, wr_en=0.
  - Throughput: one write per 2 cycles.
- Read accepted in cycle t:
  - From cycle t+1: rd_addr/rd_be hold the captured address/be; they stay stable until the next read is accepted and are never zeroed.
  - RD_WAIT lasts RD_LAT cycles (3-bit down-counter); rd_data is sampled at the end of cycle t+RD_LAT.
  - Cycle t+RD_LAT+1: RD_DONE, reqN_rvalid=1 for the original requester, reqN_rdata = sample.
  - Next cycle: IDLE.
  - reqN_rdata holds its value until the next read return to that requester.
- Only one access is outstanding; no request is accepted outside IDLE.
- A valid that drops before ready is treated as withdrawn; no side effects.
- wr_busy rising while in WR has no effect; the strobe has already been issued.

Optional Feature:
Macro PIO_ARB_WRPROT_EN.
- Defined: a req1 write whose addr[13:12] != 2'b01 (outside BAR0 user registers) is still accepted (ready pulses) but is discarded. No WR state, wr_en stays 0, prot_err is set and stays set until reset.
- Undefined: all writes are forwarded; prot_err is tied 0.

Decomposition:
- Package pio_arb_pkg: state enum (IDLE, WR, RD_WAIT, RD_DONE), NUM_REQ=2, BAR0_SEL=2'b01, default ADDR_W.
- Sub-module pio_rr_arb2: 2-way round-robin pick. Inputs: the two valid/eligible flags and last_grant. Outputs: grant index and any-grant. Purely combinational; last_grant register stays in the parent.

Test Plan:
- Both requesters issue writes in the same cycle (req0 addr 0x1000 data 0x0A0015C8; req1 addr 0x1004 data 0x0A0015FF) -> req0 granted first with wr_en at t+1; req1 granted at t+2 with wr_en at t+3; next tie goes to req0.
- req1 reads 0x1002 with RD_LAT=1, rd_data=0x00377600 -> rd_addr=0x1002 from t+1; req1_rvalid at t+2 with rdata=0x00377600; req0_rvalid stays 0.
- RD_LAT=3 read -> rd_addr stable cycles t+1..t+3; rvalid at t+4 exactly one cycle.
- wr_busy held high for 5 cycles while req0 writes and req1 reads -> req1 read proceeds; req0 ready only after wr_busy falls; exactly one wr_en pulse for req0.
- sys_rst_n pulsed low during RD_WAIT -> outputs zero immediately; no rvalid; IDLE after release; next request serviced normally.
- PIO_ARB_WRPROT_EN defined, req1 writes 0x3000 -> req1_ready pulses, wr_en never asserted, prot_err=1 and sticky. Same write from req0 -> wr_en pulses, prot_err unchanged.
